// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the WISC-S25 hazard/stall controller.
//   hz_state_e : miss-sequencing FSM encoding (RUN=0, IMISS=1, DMISS=2)
//   REG_ZERO   : hard-wired zero register, never a hazard source
// Optional feature macro used by the files importing this package:
//   HAZARD_STATS_EN
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_IMISS = 2'd1,
        HZ_DMISS = 2'd2
    } hz_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_if
// Bundle between the pipeline and the hazard/stall controller.
//   master : pipeline side; drives hazard sources, observes controls
//   slave  : hazard_stall_unit; observes sources, drives controls
// Signals:
//   id_rs/id_rt/id_rs_used/id_rt_used : ID source operands
//   ex_mem_read/ex_rd                 : EX load and its destination
//   id_br_taken                       : branch resolved taken in ID
//   icache_miss/dcache_miss           : cache miss levels
//   stall/id_ex_bubble/if_id_flush/mem_hold : pipeline register controls
//   state/err_timeout                 : FSM state and sticky miss timeout
//   stall_cycles/flush_count/lduse_count : only with HAZARD_STATS_EN
// -----------------------------------------------------------------------------
interface hazard_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             id_br_taken;
    logic             icache_miss;
    logic             dcache_miss;
    logic             stall;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             mem_hold;
    logic [1:0]       state;
    logic             err_timeout;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] lduse_count;
`endif

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
               id_br_taken, icache_miss, dcache_miss,
        input  stall, id_ex_bubble, if_id_flush, mem_hold, state, err_timeout
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_count, lduse_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
               id_br_taken, icache_miss, dcache_miss,
        output stall, id_ex_bubble, if_id_flush, mem_hold, state, err_timeout
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_count, lduse_count
`endif
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and asynchronous reset.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one (ignored once at MAX)
//   clr      : clear to zero (wins over inc)
//   cnt      : current count
//   at_max   : cnt equals MAX
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Central stall/flush controller for the 5-stage WISC-S25 pipeline.
// Detects load-use hazards and ID-resolved taken branches, sequences I/D-cache
// miss stalls, and flags misses lasting longer than MISS_TMO cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_if.slave (hazard sources in, pipeline controls out)
// Parameters: REG_W (register specifier width), CNT_W (counter width),
//             MISS_TMO (miss cycles before err_timeout).
// Optional: HAZARD_STATS_EN adds stall_cycles/flush_count/lduse_count.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int CNT_W    = 16,
    parameter int MISS_TMO = 255
) (
    input logic    clk,
    input logic    rst,
    hazard_if.slave hz
);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic             load_use;
    logic             err_q;
    logic [CNT_W-1:0] miss_cnt;
    logic             miss_at_max;
    logic             miss_clr;
    logic             miss_inc;

    // Register zero is hard-wired, so a load targeting it cannot create a hazard.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_W'(REG_ZERO)) &&
                      ((hz.id_rs_used && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_rt_used && (hz.id_rt == hz.ex_rd)));

    // Pipeline controls depend only on the current inputs, in priority order.
    // A taken branch is dropped while stalled; it re-resolves after release.
    always_comb begin
        hz.stall        = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.mem_hold     = 1'b0;
        if (hz.dcache_miss) begin
            hz.stall    = 1'b1;
            hz.mem_hold = 1'b1;
        end else if (load_use) begin
            hz.stall        = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (hz.icache_miss) begin
            hz.stall       = 1'b1;
            hz.if_id_flush = 1'b1;
        end else if (hz.id_br_taken) begin
            hz.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HZ_RUN: begin
                if (hz.dcache_miss)      state_d = HZ_DMISS;
                else if (hz.icache_miss) state_d = HZ_IMISS;
            end
            HZ_IMISS: begin
                if (hz.dcache_miss)       state_d = HZ_DMISS;
                else if (!hz.icache_miss) state_d = HZ_RUN;
            end
            HZ_DMISS: begin
                if (!hz.dcache_miss) state_d = hz.icache_miss ? HZ_IMISS : HZ_RUN;
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Miss duration restarts on every transition so a D-miss following an
    // I-miss gets its own full budget.
    assign miss_clr = (state_q == HZ_RUN) || (state_d != state_q);
    assign miss_inc = (state_q != HZ_RUN);

    sat_counter #(
        .CNT_W (CNT_W),
        .MAX   (CNT_W'(MISS_TMO))
    ) u_miss_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (miss_inc),
        .clr    (miss_clr),
        .cnt    (miss_cnt),
        .at_max (miss_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (miss_at_max) begin
            err_q <= 1'b1;
        end
    end

    assign hz.state       = state_q;
    assign hz.err_timeout = err_q;

`ifdef HAZARD_STATS_EN
    logic stall_at_max;
    logic flush_at_max;
    logic lduse_at_max;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cycles (
        .clk    (clk),
        .rst    (rst),
        .inc    (hz.stall),
        .clr    (1'b0),
        .cnt    (hz.stall_cycles),
        .at_max (stall_at_max)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_count (
        .clk    (clk),
        .rst    (rst),
        .inc    (hz.if_id_flush && !hz.stall),
        .clr    (1'b0),
        .cnt    (hz.flush_count),
        .at_max (flush_at_max)
    );

    // A load-use event is counted only when it actually inserts a bubble.
    sat_counter #(.CNT_W(CNT_W)) u_lduse_count (
        .clk    (clk),
        .rst    (rst),
        .inc    (hz.id_ex_bubble),
        .clr    (1'b0),
        .cnt    (hz.lduse_count),
        .at_max (lduse_at_max)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit: load-use, I-miss, nested D-miss,
// branch vs load-use priority, miss timeout boundary and asynchronous reset.
// Builds with or without HAZARD_STATS_EN.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int REG_W    = 4;
    localparam int CNT_W    = 16;
    localparam int MISS_TMO = 255;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_stall_unit #(
        .REG_W    (REG_W),
        .CNT_W    (CNT_W),
        .MISS_TMO (MISS_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs       = '0;
        hz.id_rt       = '0;
        hz.id_rs_used  = 1'b0;
        hz.id_rt_used  = 1'b0;
        hz.ex_mem_read = 1'b0;
        hz.ex_rd       = '0;
        hz.id_br_taken = 1'b0;
        hz.icache_miss = 1'b0;
        hz.dcache_miss = 1'b0;
    endtask

    // stall, bubble, flush, hold packed as a 4-bit vector for compact checks
    function automatic logic [31:0] ctl();
        return {28'd0, hz.stall, hz.id_ex_bubble, hz.if_id_flush, hz.mem_hold};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(hz.state), 32'd0);
        chk("rst_err",   32'(hz.err_timeout), 32'd0);
        chk("rst_ctl",   ctl(), 32'b0000);
`ifdef HAZARD_STATS_EN
        chk("rst_stallc", 32'(hz.stall_cycles), 32'd0);
        chk("rst_flushc", 32'(hz.flush_count), 32'd0);
        chk("rst_lduse",  32'(hz.lduse_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();

        // Load-use on rs: one-cycle stall+bubble, gone once the load leaves EX
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd3; hz.id_rs = 4'd3; hz.id_rs_used = 1'b1;
        #1 chk("lu_rs", ctl(), 32'b1100);
        step();
        hz.ex_mem_read = 1'b0;
        #1 chk("lu_released", ctl(), 32'b0000);
        chk("lu_state", 32'(hz.state), 32'd0);
        // Load-use on rt
        idle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd5; hz.id_rt = 4'd5; hz.id_rt_used = 1'b1;
        #1 chk("lu_rt", ctl(), 32'b1100);
        // Matching rs but not read: no hazard
        idle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd5; hz.id_rs = 4'd5; hz.id_rs_used = 1'b0;
        #1 chk("lu_unused", ctl(), 32'b0000);
        // Register zero never hazards
        idle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd0; hz.id_rs = 4'd0; hz.id_rs_used = 1'b1;
        #1 chk("lu_r0", ctl(), 32'b0000);
        idle();
        step();

        // I-cache miss for 4 cycles
        hz.icache_miss = 1'b1;
        #1 chk("im_ctl0", ctl(), 32'b1010);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("im_state%0d", i), 32'(hz.state), 32'd1);
            chk($sformatf("im_ctl%0d", i + 1), ctl(), 32'b1010);
        end
        hz.icache_miss = 1'b0;
        #1 chk("im_drop_ctl", ctl(), 32'b0000);
        step();
        chk("im_run", 32'(hz.state), 32'd0);

        // D-miss nested inside I-miss
        hz.icache_miss = 1'b1;
        step();
        chk("nest_imiss", 32'(hz.state), 32'd1);
        hz.dcache_miss = 1'b1;
        #1 chk("nest_ctl_d", ctl(), 32'b1001);
        step();
        chk("nest_dmiss", 32'(hz.state), 32'd2);
        hz.dcache_miss = 1'b0;
        step();
        chk("nest_back_i", 32'(hz.state), 32'd1);
        chk("nest_ctl_i", ctl(), 32'b1010);
        hz.icache_miss = 1'b0;
        step();
        chk("nest_run", 32'(hz.state), 32'd0);

        // Taken branch coinciding with load-use is suppressed, then flushes
        hz.id_br_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd7; hz.id_rt = 4'd7; hz.id_rt_used = 1'b1;
        #1 chk("br_lu", ctl(), 32'b1100);
        step();
        hz.ex_mem_read = 1'b0;
        #1 chk("br_flush", ctl(), 32'b0010);
        idle();
        step();

        // D-miss for exactly MISS_TMO cycles: no timeout
        hz.dcache_miss = 1'b1;
        repeat (MISS_TMO) step();
        hz.dcache_miss = 1'b0;
        step();
        step();
        chk("tmo_edge_err", 32'(hz.err_timeout), 32'd0);

        // D-miss for MISS_TMO+1 cycles: timeout, sticky after release
        hz.dcache_miss = 1'b1;
        repeat (MISS_TMO + 1) step();
        chk("tmo_held_state", 32'(hz.state), 32'd2);
        hz.dcache_miss = 1'b0;
        step();
        chk("tmo_err", 32'(hz.err_timeout), 32'd1);
        chk("tmo_run", 32'(hz.state), 32'd0);
        repeat (3) step();
        chk("tmo_sticky", 32'(hz.err_timeout), 32'd1);

        // Asynchronous reset in the middle of a D-miss
        hz.dcache_miss = 1'b1;
        step();
        step();
        chk("rm_dmiss", 32'(hz.state), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rm_state", 32'(hz.state), 32'd0);
        chk("rm_err",   32'(hz.err_timeout), 32'd0);
        chk("rm_hold",  ctl(), 32'b1001);
`ifdef HAZARD_STATS_EN
        chk("rm_stallc", 32'(hz.stall_cycles), 32'd0);
        chk("rm_flushc", 32'(hz.flush_count), 32'd0);
        chk("rm_lduse",  32'(hz.lduse_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rm_reenter", 32'(hz.state), 32'd2);
        hz.dcache_miss = 1'b0;
        step();
        chk("rm_run", 32'(hz.state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
